// File: rtl/otter_trap_ctrl.sv
// ---------------------------------------------------------------------------
// otter_trap_ctrl
//   Trap controller for the OTTER execute stage. Each cycle in IDLE it looks
//   at the executing instruction and the interrupt lines, picks the single
//   highest-priority trap cause, and latches a trap record (mcause, mepc,
//   mtval) together with the handler address. The record is offered to the
//   CSR file on a valid/ready handshake. After acceptance fetch is redirected
//   to the handler with a one-cycle strobe.
//
//   Priority (high -> low): enabled interrupt, illegal instruction,
//   ECALL/EBREAK, misaligned jump/branch target, misaligned load,
//   misaligned store.
//
// Parameters
//   XLEN    data/address width
//   IALIGN  instruction alignment in bytes (2 or 4)
//   NUM_IRQ number of interrupt lines (1..XLEN-1)
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   instr_valid, instrn, pc     executing instruction and its pc
//   jal_addr, jalr_addr         jump targets
//   branch_addr, branch_taken   branch target and condition
//   illegal                     decoder flags instrn illegal
//   mem_addr, ld_misalign,
//   st_misalign                 load/store address and misalign flags
//   irq, irq_en, mie_global     interrupt pending, per-line enable, global enable
//   mtvec                       trap vector base + mode
//   csr_ready                   CSR file accepts the trap record
//   trap_valid                  trap record valid
//   mcause, mepc, mtval         trap record
//   flush, busy                 high whenever the controller is not IDLE
//   pc_sel_trap, trap_pc        one-cycle redirect strobe and handler address
// ---------------------------------------------------------------------------
module otter_trap_ctrl #(
  parameter int XLEN    = 32,
  parameter int IALIGN  = 4,
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        instrn,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    jal_addr,
  input  logic [XLEN-1:0]    jalr_addr,
  input  logic [XLEN-1:0]    branch_addr,
  input  logic               branch_taken,
  input  logic               illegal,
  input  logic [XLEN-1:0]    mem_addr,
  input  logic               ld_misalign,
  input  logic               st_misalign,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               mie_global,
  input  logic [XLEN-1:0]    mtvec,
  input  logic               csr_ready,
  output logic               trap_valid,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mepc,
  output logic [XLEN-1:0]    mtval,
  output logic               flush,
  output logic               pc_sel_trap,
  output logic [XLEN-1:0]    trap_pc,
  output logic               busy
);

  // RV32I major opcodes for control transfers
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [XLEN-1:0] ALIGN_MASK    = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] CAUSE_IMISAL  = XLEN'(0);
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_BREAK   = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_LDMIS   = XLEN'(4);
  localparam logic [XLEN-1:0] CAUSE_STMIS   = XLEN'(6);
  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t            state_q;
  logic              trap_valid_q;
  logic              pc_sel_q;
  logic              busy_q;
  logic [XLEN-1:0]   mcause_q, mepc_q, mtval_q, trap_pc_q;

  // Combinational trap detection
  logic [NUM_IRQ-1:0] irq_act;
  logic               irq_hit;
  logic [IDX_W-1:0]   irq_idx;
  logic [6:0]         opcode;
  logic               jal_mis, jalr_mis, br_mis;
  logic               cause_hit_d;
  logic               is_irq_d;
  logic [XLEN-1:0]    cause_d, tval_d, base_d, tpc_d;

  always_comb begin
    irq_act = irq & irq_en;
    irq_hit = mie_global && (|irq_act);
    // Ascending scan: the last (highest) enabled pending line wins
    irq_idx = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (irq_act[k]) irq_idx = k[IDX_W-1:0];
    end

    opcode   = instrn[6:0];
    jal_mis  = (opcode == OPCODE_JAL)  && ((jal_addr  & ALIGN_MASK) != '0);
    jalr_mis = (opcode == OPCODE_JALR) && ((jalr_addr & ALIGN_MASK) != '0);
    br_mis   = (opcode == OPCODE_BRANCH) && branch_taken &&
               ((branch_addr & ALIGN_MASK) != '0);

    cause_hit_d = 1'b1;
    is_irq_d    = 1'b0;
    cause_d     = '0;
    tval_d      = '0;
    if (irq_hit) begin
      is_irq_d          = 1'b1;
      cause_d           = XLEN'(irq_idx);
      cause_d[XLEN-1]   = 1'b1;
    end else if (illegal) begin
      cause_d = CAUSE_ILLEGAL;
      tval_d  = XLEN'(instrn);
    end else if (instrn == INSTR_ECALL) begin
      cause_d = CAUSE_ECALL;
    end else if (instrn == INSTR_EBREAK) begin
      cause_d = CAUSE_BREAK;
    end else if (jal_mis) begin
      cause_d = CAUSE_IMISAL;
      tval_d  = jal_addr;
    end else if (jalr_mis) begin
      cause_d = CAUSE_IMISAL;
      tval_d  = jalr_addr;
    end else if (br_mis) begin
      cause_d = CAUSE_IMISAL;
      tval_d  = branch_addr;
    end else if (ld_misalign) begin
      cause_d = CAUSE_LDMIS;
      tval_d  = mem_addr;
    end else if (st_misalign) begin
      cause_d = CAUSE_STMIS;
      tval_d  = mem_addr;
    end else begin
      cause_hit_d = 1'b0;
    end

    // Only mode 1 vectors, and only for interrupts; modes 2/3 act as direct
    base_d = {mtvec[XLEN-1:2], 2'b00};
    if (is_irq_d && (mtvec[1:0] == 2'b01)) begin
      tpc_d = base_d + (XLEN'(irq_idx) << 2);
    end else begin
      tpc_d = base_d;
    end
  end

  // Trap sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      trap_valid_q <= 1'b0;
      pc_sel_q     <= 1'b0;
      busy_q       <= 1'b0;
      mcause_q     <= '0;
      mepc_q       <= '0;
      mtval_q      <= '0;
      trap_pc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid && cause_hit_d) begin
            state_q      <= ST_COMMIT;
            trap_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            mcause_q     <= cause_d;
            mepc_q       <= pc;
            mtval_q      <= tval_d;
            trap_pc_q    <= tpc_d;
          end
        end
        ST_COMMIT: begin
          // Record stays frozen until the CSR file takes it
          if (csr_ready) begin
            state_q      <= ST_REDIRECT;
            trap_valid_q <= 1'b0;
            pc_sel_q     <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          // Causes visible this cycle are deliberately dropped
          state_q   <= ST_IDLE;
          pc_sel_q  <= 1'b0;
          busy_q    <= 1'b0;
          mcause_q  <= '0;
          mepc_q    <= '0;
          mtval_q   <= '0;
          trap_pc_q <= '0;
        end
        default: begin
          state_q      <= ST_IDLE;
          trap_valid_q <= 1'b0;
          pc_sel_q     <= 1'b0;
          busy_q       <= 1'b0;
          mcause_q     <= '0;
          mepc_q       <= '0;
          mtval_q      <= '0;
          trap_pc_q    <= '0;
        end
      endcase
    end
  end

  assign trap_valid  = trap_valid_q;
  assign mcause      = mcause_q;
  assign mepc        = mepc_q;
  assign mtval       = mtval_q;
  assign flush       = busy_q;
  assign busy        = busy_q;
  assign pc_sel_trap = pc_sel_q;
  assign trap_pc     = trap_pc_q;

endmodule

// File: tb/tb_otter_trap_ctrl.sv
module tb_otter_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instrn, pc, jal_addr, jalr_addr, branch_addr, mem_addr, mtvec;
  logic        branch_taken, illegal, ld_misalign, st_misalign, mie_global, csr_ready;
  logic [7:0]  irq, irq_en;

  logic        tv4, fl4, ps4, bz4;
  logic [31:0] mc4, me4, mt4, tp4;
  logic        tv2, fl2, ps2, bz2;
  logic [31:0] mc2, me2, mt2, tp2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  otter_trap_ctrl #(.XLEN(32), .IALIGN(4), .NUM_IRQ(8)) dut4 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instrn(instrn), .pc(pc),
    .jal_addr(jal_addr), .jalr_addr(jalr_addr), .branch_addr(branch_addr),
    .branch_taken(branch_taken), .illegal(illegal), .mem_addr(mem_addr),
    .ld_misalign(ld_misalign), .st_misalign(st_misalign), .irq(irq), .irq_en(irq_en),
    .mie_global(mie_global), .mtvec(mtvec), .csr_ready(csr_ready),
    .trap_valid(tv4), .mcause(mc4), .mepc(me4), .mtval(mt4), .flush(fl4),
    .pc_sel_trap(ps4), .trap_pc(tp4), .busy(bz4));

  otter_trap_ctrl #(.XLEN(32), .IALIGN(2), .NUM_IRQ(8)) dut2 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instrn(instrn), .pc(pc),
    .jal_addr(jal_addr), .jalr_addr(jalr_addr), .branch_addr(branch_addr),
    .branch_taken(branch_taken), .illegal(illegal), .mem_addr(mem_addr),
    .ld_misalign(ld_misalign), .st_misalign(st_misalign), .irq(irq), .irq_en(irq_en),
    .mie_global(mie_global), .mtvec(mtvec), .csr_ready(csr_ready),
    .trap_valid(tv2), .mcause(mc2), .mepc(me2), .mtval(mt2), .flush(fl2),
    .pc_sel_trap(ps2), .trap_pc(tp2), .busy(bz2));

  task automatic clear_inputs();
    instr_valid = 0; instrn = 32'h0000_0013; pc = 0; jal_addr = 0; jalr_addr = 0;
    branch_addr = 0; branch_taken = 0; illegal = 0; mem_addr = 0; ld_misalign = 0;
    st_misalign = 0; irq = 0; irq_en = 0; mie_global = 0; mtvec = 0; csr_ready = 0;
  endtask

  // Let any in-flight trap drain back to IDLE
  task automatic drain();
    clear_inputs();
    csr_ready = 1;
    repeat (3) @(negedge clk);
    csr_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    tests++; if ({tv4, fl4, ps4, bz4} !== 4'b0) begin fails++; $display("FAIL reset_ctl4 got %b exp 0000", {tv4, fl4, ps4, bz4}); end
    tests++; if ({mc4, me4, mt4, tp4} !== 128'h0) begin fails++; $display("FAIL reset_rec4 got %h exp 0", {mc4, me4, mt4, tp4}); end
    tests++; if ({tv2, fl2, ps2, bz2} !== 4'b0) begin fails++; $display("FAIL reset_ctl2 got %b exp 0000", {tv2, fl2, ps2, bz2}); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_jal_misalign();
    clear_inputs();
    instr_valid = 1; instrn = 32'h0000_006F; pc = 32'h100; jal_addr = 32'h102; mtvec = 32'h2000;
    @(negedge clk);
    tests++; if (tv4 !== 1'b1) begin fails++; $display("FAIL jal_tv4 got %b exp 1", tv4); end
    tests++; if (mc4 !== 32'h0) begin fails++; $display("FAIL jal_mcause got %h exp 0", mc4); end
    tests++; if (mt4 !== 32'h102) begin fails++; $display("FAIL jal_mtval got %h exp 102", mt4); end
    tests++; if (me4 !== 32'h100) begin fails++; $display("FAIL jal_mepc got %h exp 100", me4); end
    tests++; if ({fl4, bz4} !== 2'b11) begin fails++; $display("FAIL jal_flush_busy got %b exp 11", {fl4, bz4}); end
    tests++; if ({tv2, fl2} !== 2'b00) begin fails++; $display("FAIL jal_ialign2 got %b exp 00", {tv2, fl2}); end
    instr_valid = 0; csr_ready = 1;
    @(negedge clk);
    tests++; if ({ps4, tv4} !== 2'b10) begin fails++; $display("FAIL jal_redirect got %b exp 10", {ps4, tv4}); end
    tests++; if (tp4 !== 32'h2000) begin fails++; $display("FAIL jal_trap_pc got %h exp 2000", tp4); end
    @(negedge clk);
    tests++; if ({ps4, bz4, tv4} !== 3'b000) begin fails++; $display("FAIL jal_back_idle got %b exp 000", {ps4, bz4, tv4}); end
    tests++; if ({mc4, me4, mt4, tp4} !== 128'h0) begin fails++; $display("FAIL jal_rec_clear got %h exp 0", {mc4, me4, mt4, tp4}); end
    drain();
  endtask

  task automatic test_branch();
    clear_inputs();
    instr_valid = 1; instrn = 32'h0000_0063; pc = 32'h1F0; branch_addr = 32'h201; branch_taken = 1;
    @(negedge clk);
    tests++; if ({tv4, mc4, mt4} !== {1'b1, 32'h0, 32'h201}) begin fails++; $display("FAIL br_taken got %b/%h/%h exp 1/0/201", tv4, mc4, mt4); end
    drain();
    instr_valid = 1; instrn = 32'h0000_0063; pc = 32'h1F0; branch_addr = 32'h201; branch_taken = 0;
    @(negedge clk);
    tests++; if ({tv4, fl4, tv2, fl2} !== 4'b0) begin fails++; $display("FAIL br_not_taken got %b exp 0000", {tv4, fl4, tv2, fl2}); end
    drain();
  endtask

  task automatic test_irq_priority();
    clear_inputs();
    instr_valid = 1; instrn = 32'hFFFF_FFFF; illegal = 1; pc = 32'h400;
    irq = 8'b0010_0100; irq_en = 8'hFF; mie_global = 1; mtvec = 32'h1001;
    @(negedge clk);
    tests++; if (mc4 !== 32'h8000_0005) begin fails++; $display("FAIL irq_mcause got %h exp 80000005", mc4); end
    tests++; if (tp4 !== 32'h1014) begin fails++; $display("FAIL irq_trap_pc got %h exp 1014", tp4); end
    tests++; if ({me4, mt4} !== {32'h400, 32'h0}) begin fails++; $display("FAIL irq_mepc_mtval got %h/%h exp 400/0", me4, mt4); end
    // Dropping the interrupt while committing must not cancel the trap
    irq = 0; instr_valid = 0; illegal = 0;
    @(negedge clk);
    tests++; if ({tv4, mc4} !== {1'b1, 32'h8000_0005}) begin fails++; $display("FAIL irq_drop got %b/%h exp 1/80000005", tv4, mc4); end
    drain();
  endtask

  task automatic test_ld_stall();
    clear_inputs();
    instr_valid = 1; instrn = 32'h0000_2003; pc = 32'h500; ld_misalign = 1; mem_addr = 32'h3;
    @(negedge clk);
    instr_valid = 0; ld_misalign = 0; mem_addr = 32'hABCD;
    for (int c = 0; c < 4; c++) begin
      tests++; if ({tv4, ps4, mc4, mt4, me4} !== {2'b10, 32'h4, 32'h3, 32'h500}) begin
        fails++; $display("FAIL ld_hold[%0d] got %b%b/%h/%h/%h exp 10/4/3/500", c, tv4, ps4, mc4, mt4, me4); end
      @(negedge clk);
    end
    tests++; if (tv4 !== 1'b1) begin fails++; $display("FAIL ld_hold_last got %b exp 1", tv4); end
    csr_ready = 1;
    @(negedge clk);
    tests++; if ({tv4, ps4} !== 2'b01) begin fails++; $display("FAIL ld_accept got %b exp 01", {tv4, ps4}); end
    @(negedge clk);
    tests++; if ({ps4, bz4} !== 2'b00) begin fails++; $display("FAIL ld_strobe_once got %b exp 00", {ps4, bz4}); end
    drain();
  endtask

  task automatic test_ecall();
    clear_inputs();
    instr_valid = 1; instrn = 32'h0000_0073; pc = 32'h600; irq = 8'h01; irq_en = 8'h01;
    mie_global = 0; mtvec = 32'h3001;
    @(negedge clk);
    tests++; if ({mc4, tp4, mt4} !== {32'd11, 32'h3000, 32'h0}) begin fails++; $display("FAIL ecall got %h/%h/%h exp b/3000/0", mc4, tp4, mt4); end
    drain();
  endtask

  task automatic test_reset_commit();
    clear_inputs();
    instr_valid = 1; illegal = 1; instrn = 32'hDEAD_BEEF; pc = 32'h700;
    @(negedge clk);
    tests++; if (tv4 !== 1'b1) begin fails++; $display("FAIL rstc_commit got %b exp 1", tv4); end
    rst = 1;
    #1;
    tests++; if ({tv4, fl4, bz4, mc4, mt4, tp4} !== 99'h0) begin fails++; $display("FAIL rstc_async got %b%b%b/%h/%h exp 0", tv4, fl4, bz4, mc4, mt4); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    tests++; if ({tv4, mc4, mt4, me4} !== {1'b1, 32'd2, 32'hDEAD_BEEF, 32'h700}) begin
      fails++; $display("FAIL rstc_retrap got %b/%h/%h/%h exp 1/2/deadbeef/700", tv4, mc4, mt4, me4); end
    drain();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    instr_valid = 1; instrn = 32'h0010_0073; pc = 32'h800;
    @(negedge clk);
    tests++; if (mc4 !== 32'd3) begin fails++; $display("FAIL b2b_ebreak got %h exp 3", mc4); end
    csr_ready = 1; instrn = 32'h0000_2023; st_misalign = 1; mem_addr = 32'h11; pc = 32'h804;
    @(negedge clk);
    tests++; if (ps4 !== 1'b1) begin fails++; $display("FAIL b2b_redirect got %b exp 1", ps4); end
    @(negedge clk);
    tests++; if ({tv4, bz4} !== 2'b00) begin fails++; $display("FAIL b2b_skip got %b exp 00", {tv4, bz4}); end
    @(negedge clk);
    tests++; if ({tv4, mc4, mt4, me4} !== {1'b1, 32'd6, 32'h11, 32'h804}) begin
      fails++; $display("FAIL b2b_store got %b/%h/%h/%h exp 1/6/11/804", tv4, mc4, mt4, me4); end
    drain();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_jal_misalign();
    test_branch();
    test_irq_priority();
    test_ld_stall();
    test_ecall();
    test_reset_commit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
